// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store memory stage between execute and writeback.
//   Computes ea = rs1 + imm, issues one data-memory request per aligned load or
//   store, and holds the request until dddr_resp or a bus timeout. Load data is
//   lane-extracted and sign/zero extended. Misaligned ops complete immediately
//   with exc=1. mem_busy stalls the upstream stages while an access is open.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     downstream stall, freezes mem_wb_*
//   ex_*                      execute-stage op (valid, load/store, width, data, rd)
//   dddr_addr/read/write/be/wdata   registered memory request (held in ACCESS)
//   dddr_rdata, dddr_resp     memory read data and single-cycle completion
//   mem_busy                  stall request to upstream
//   mem_wb_valid/rd/data/exc  registered writeback result
module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_dwidth,
    input  logic              ex_unsigned,
    input  logic [XLEN-1:0]   ex_rs1_data,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [XLEN-1:0]   ex_rd_data,
    input  logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   dddr_addr,
    output logic              dddr_read,
    output logic              dddr_write,
    output logic [XLEN/8-1:0] dddr_be,
    output logic [XLEN-1:0]   dddr_wdata,
    input  logic [XLEN-1:0]   dddr_rdata,
    input  logic              dddr_resp,
    output logic              mem_busy,
    output logic              mem_wb_valid,
    output logic [4:0]        mem_wb_rd,
    output logic [XLEN-1:0]   mem_wb_data,
    output logic [1:0]        mem_wb_exc
);
    localparam int BE_W = XLEN / 8;
    localparam int OW   = $clog2(BE_W);
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_MISAL = 2'd1;
    localparam logic [1:0] EXC_BUS   = 2'd2;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [1:0]      exc;
    } wb_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [1:0]      width_q, width_d;
    logic            uns_q, uns_d;
    logic [OW-1:0]   off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    wb_t             wb_q, wb_d;
    wb_t             hold_q, hold_d;
    logic            hold_vld_q, hold_vld_d;

    logic [XLEN-1:0] ea, amask, ea_wdata;
    logic [BE_W-1:0] be_base, ea_be;
    logic            is_mem, misal;
    logic [XLEN-1:0] ld_shift, ld_mask, ld_data;
    logic            ld_sign;
    logic            done;
    wb_t             done_res;

    // Execute-side decode: address, alignment, lane enables and store data.
    always_comb begin
        ea     = ex_rs1_data + ex_imm;
        is_mem = ex_valid & (ex_load | ex_store);
        amask  = XLEN'((1 << ex_dwidth) - 1);
        // A dword op on a 32-bit datapath has no legal lane mapping; it is
        // reported as misaligned rather than issued.
        misal  = (|(ea & amask)) | ((XLEN == 32) && (ex_dwidth == 2'd3));
        case (ex_dwidth)
            2'd0:    be_base = BE_W'(1);
            2'd1:    be_base = BE_W'(3);
            2'd2:    be_base = BE_W'(15);
            default: be_base = '1;
        endcase
        ea_be = be_base << ea[OW-1:0];
        // Replicate the low access-width bytes of rs2 across every lane.
        ea_wdata = '0;
        for (int i = 0; i < BE_W; i++) begin
            ea_wdata[8*i +: 8] = ex_rs2_data[8*((i & int'(amask[2:0])) % BE_W) +: 8];
        end
    end

    // Load return path: shift addressed lane down, mask to width, extend.
    always_comb begin
        ld_shift = dddr_rdata >> {off_q, 3'b000};
        case (width_q)
            2'd0:    ld_mask = XLEN'(8'hFF);
            2'd1:    ld_mask = XLEN'(16'hFFFF);
            2'd2:    ld_mask = XLEN'(32'hFFFF_FFFF);
            default: ld_mask = '1;
        endcase
        // mask ^ (mask >> 1) isolates the top bit of the access width
        ld_sign = ~uns_q & (|(ld_shift & (ld_mask ^ (ld_mask >> 1))));
        ld_data = (ld_shift & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

    // FSM next state, request fields and writeback selection.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        read_d     = read_q;
        write_d    = write_q;
        width_d    = width_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_d       = wb_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        mem_busy   = 1'b0;
        done       = 1'b0;
        done_res   = '0;

        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    // A completed result is parked; ex_* still shows the
                    // finished op, so nothing new is accepted this cycle.
                    mem_busy = stall;
                    if (!stall) begin
                        wb_d       = hold_q;
                        hold_vld_d = 1'b0;
                    end
                end else if (is_mem && !misal) begin
                    mem_busy = 1'b1;
                    state_d  = ACCESS;
                    addr_d   = ea & ~XLEN'(BE_W - 1);
                    be_d     = ea_be;
                    wdata_d  = ea_wdata;
                    read_d   = ex_load;
                    write_d  = ex_store & ~ex_load;
                    width_d  = ex_dwidth;
                    uns_d    = ex_unsigned;
                    off_d    = ea[OW-1:0];
                    rd_d     = ex_rd;
                    cnt_d    = '0;
                    if (!stall) wb_d.valid = 1'b0;
                end else if (!stall) begin
                    wb_d.valid = ex_valid;
                    wb_d.rd    = ex_rd;
                    wb_d.data  = is_mem ? '0 : ex_rd_data;
                    wb_d.exc   = is_mem ? EXC_MISAL : EXC_NONE;
                end
            end
            ACCESS: begin
                done_res.valid = 1'b1;
                done_res.rd    = rd_q;
                if (dddr_resp) begin
                    done          = 1'b1;
                    done_res.data = read_q ? ld_data : '0;
                    done_res.exc  = EXC_NONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1))) begin
                    done          = 1'b1;
                    done_res.data = '0;
                    done_res.exc  = EXC_BUS;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end

                if (done) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    cnt_d   = '0;
                    if (!stall) begin
                        wb_d = done_res;
                    end else begin
                        hold_d     = done_res;
                        hold_vld_d = 1'b1;
                    end
                    // Release upstream only once the result is actually written.
                    mem_busy = stall;
                end else begin
                    mem_busy = 1'b1;
                    if (!stall) wb_d.valid = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            width_q    <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            read_q     <= read_d;
            write_q    <= write_d;
            width_q    <= width_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_q       <= wb_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    assign dddr_addr    = addr_q;
    assign dddr_read    = read_q;
    assign dddr_write   = write_q;
    assign dddr_be      = be_q;
    assign dddr_wdata   = wdata_q;
    assign mem_wb_valid = wb_q.valid;
    assign mem_wb_rd    = wb_q.rd;
    assign mem_wb_data  = wb_q.data;
    assign mem_wb_exc   = wb_q.exc;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    logic        clk, rst, stall;
    logic        ex_valid, ex_load, ex_store, ex_unsigned;
    logic [1:0]  ex_dwidth;
    logic [31:0] ex_rs1_data, ex_imm, ex_rs2_data, ex_rd_data;
    logic [4:0]  ex_rd;
    logic [31:0] dddr_rdata;
    logic        dddr_resp;

    // dut_a: long timeout, used for everything except the timeout scenario
    logic [31:0] dddr_addr, dddr_wdata, mem_wb_data;
    logic        dddr_read, dddr_write, mem_busy, mem_wb_valid;
    logic [3:0]  dddr_be;
    logic [4:0]  mem_wb_rd;
    logic [1:0]  mem_wb_exc;
    // dut_b: TIMEOUT=4
    logic [31:0] b_dddr_addr, b_dddr_wdata, b_mem_wb_data;
    logic        b_dddr_read, b_dddr_write, b_mem_busy, b_mem_wb_valid;
    logic [3:0]  b_dddr_be;
    logic [4:0]  b_mem_wb_rd;
    logic [1:0]  b_mem_wb_exc;

    int checks = 0;
    int failures = 0;

    logic [31:0] phys  [16];
    logic [7:0]  model [64];

    mem_stage_lsu #(.XLEN(32), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_dwidth(ex_dwidth), .ex_unsigned(ex_unsigned),
        .ex_rs1_data(ex_rs1_data), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data),
        .ex_rd_data(ex_rd_data), .ex_rd(ex_rd),
        .dddr_addr(dddr_addr), .dddr_read(dddr_read), .dddr_write(dddr_write),
        .dddr_be(dddr_be), .dddr_wdata(dddr_wdata),
        .dddr_rdata(dddr_rdata), .dddr_resp(dddr_resp),
        .mem_busy(mem_busy), .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
        .mem_wb_data(mem_wb_data), .mem_wb_exc(mem_wb_exc)
    );

    mem_stage_lsu #(.XLEN(32), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_dwidth(ex_dwidth), .ex_unsigned(ex_unsigned),
        .ex_rs1_data(ex_rs1_data), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data),
        .ex_rd_data(ex_rd_data), .ex_rd(ex_rd),
        .dddr_addr(b_dddr_addr), .dddr_read(b_dddr_read), .dddr_write(b_dddr_write),
        .dddr_be(b_dddr_be), .dddr_wdata(b_dddr_wdata),
        .dddr_rdata(dddr_rdata), .dddr_resp(dddr_resp),
        .mem_busy(b_mem_busy), .mem_wb_valid(b_mem_wb_valid), .mem_wb_rd(b_mem_wb_rd),
        .mem_wb_data(b_mem_wb_data), .mem_wb_exc(b_mem_wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic idle_inputs();
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_unsigned = 0; ex_dwidth = 0;
        ex_rs1_data = 0; ex_imm = 0; ex_rs2_data = 0; ex_rd_data = 0; ex_rd = 0;
        dddr_resp = 0; dddr_rdata = 0; stall = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drive_mem(input bit ld, input bit st, input logic [1:0] dw, input bit uns,
                             input logic [31:0] rs1, input logic [31:0] imm,
                             input logic [31:0] rs2, input logic [4:0] rd);
        ex_valid = 1; ex_load = ld; ex_store = st; ex_dwidth = dw; ex_unsigned = uns;
        ex_rs1_data = rs1; ex_imm = imm; ex_rs2_data = rs2; ex_rd = rd; ex_rd_data = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; idle_inputs();
        @(negedge clk);
        checks++;
        if ({dddr_read, dddr_write, dddr_be} !== 6'd0) begin
            failures++; $display("FAIL reset_req: got rd=%b wr=%b be=%b want 0", dddr_read, dddr_write, dddr_be);
        end
        checks++;
        if ({dddr_addr, dddr_wdata} !== 64'd0) begin
            failures++; $display("FAIL reset_addr: got addr=%h wdata=%h want 0", dddr_addr, dddr_wdata);
        end
        checks++;
        if (mem_busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", mem_busy);
        end
        checks++;
        if ({mem_wb_valid, mem_wb_rd, mem_wb_data, mem_wb_exc} !== 40'd0) begin
            failures++; $display("FAIL reset_wb: got v=%b rd=%0d d=%h exc=%0d want 0", mem_wb_valid, mem_wb_rd, mem_wb_data, mem_wb_exc);
        end
        rst = 0;
    endtask

    task automatic test_lb();
        logic [31:0] exp;
        for (int u = 0; u < 2; u++) begin
            do_reset();
            @(negedge clk);
            drive_mem(1, 0, 2'd0, u[0], 32'h1000, 32'd3, 32'h0, 5'd5);
            #1;
            checks++;
            if (mem_busy !== 1'b1) begin
                failures++; $display("FAIL lb_busy_issue: got %b want 1", mem_busy);
            end
            @(negedge clk);
            checks++;
            if ({dddr_read, dddr_write} !== 2'b10) begin
                failures++; $display("FAIL lb_dir: got rd=%b wr=%b want 1/0", dddr_read, dddr_write);
            end
            checks++;
            if (dddr_addr !== 32'h1000 || dddr_be !== 4'b1000) begin
                failures++; $display("FAIL lb_req: got addr=%h be=%b want 00001000/1000", dddr_addr, dddr_be);
            end
            dddr_resp = 1; dddr_rdata = 32'h80A5_5A11;
            @(negedge clk);
            dddr_resp = 0; ex_valid = 0;
            exp = (u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80;
            checks++;
            if (mem_wb_valid !== 1'b1 || mem_wb_data !== exp || mem_wb_rd !== 5'd5 || mem_wb_exc !== 2'd0) begin
                failures++; $display("FAIL lb_result: got v=%b d=%h rd=%0d exc=%0d want 1/%h/5/0",
                                     mem_wb_valid, mem_wb_data, mem_wb_rd, mem_wb_exc, exp);
            end
        end
    endtask

    task automatic test_sh();
        do_reset();
        @(negedge clk);
        drive_mem(0, 1, 2'd1, 0, 32'h2000, 32'd2, 32'h1234_ABCD, 5'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ({dddr_read, dddr_write} !== 2'b01) begin
                failures++; $display("FAIL sh_held_c%0d: got rd=%b wr=%b want 0/1", c, dddr_read, dddr_write);
            end
            checks++;
            if (dddr_be !== 4'b1100 || dddr_wdata !== 32'hABCD_ABCD || dddr_addr !== 32'h2000) begin
                failures++; $display("FAIL sh_fields_c%0d: got be=%b wd=%h addr=%h want 1100/abcdabcd/00002000",
                                     c, dddr_be, dddr_wdata, dddr_addr);
            end
            if (c == 5) dddr_resp = 1;
        end
        @(negedge clk);
        dddr_resp = 0; ex_valid = 0;
        checks++;
        if (dddr_write !== 1'b0 || mem_wb_valid !== 1'b1 || mem_wb_exc !== 2'd0) begin
            failures++; $display("FAIL sh_done: got wr=%b v=%b exc=%0d want 0/1/0", dddr_write, mem_wb_valid, mem_wb_exc);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        @(negedge clk);
        drive_mem(1, 0, 2'd2, 0, 32'h1000, 32'd2, 32'h0, 5'd3);
        #1;
        checks++;
        if (mem_busy !== 1'b0) begin
            failures++; $display("FAIL mis_busy: got %b want 0", mem_busy);
        end
        @(negedge clk);
        ex_valid = 0;
        checks++;
        if ({dddr_read, dddr_write} !== 2'b00) begin
            failures++; $display("FAIL mis_noreq: got rd=%b wr=%b want 0/0", dddr_read, dddr_write);
        end
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_wb_exc !== 2'd1 || mem_wb_rd !== 5'd3) begin
            failures++; $display("FAIL mis_exc: got v=%b exc=%0d rd=%0d want 1/1/3", mem_wb_valid, mem_wb_exc, mem_wb_rd);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        drive_mem(1, 0, 2'd2, 0, 32'h3000, 32'd0, 32'h0, 5'd4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (b_dddr_read !== 1'b1) begin
                failures++; $display("FAIL tmo_held_c%0d: got rd=%b want 1", c, b_dddr_read);
            end
        end
        #1;
        checks++;
        if (b_mem_busy !== 1'b0) begin
            failures++; $display("FAIL tmo_busy_release: got %b want 0", b_mem_busy);
        end
        @(negedge clk);
        ex_valid = 0;
        checks++;
        if (b_dddr_read !== 1'b0) begin
            failures++; $display("FAIL tmo_drop: got rd=%b want 0", b_dddr_read);
        end
        checks++;
        if (b_mem_wb_valid !== 1'b1 || b_mem_wb_exc !== 2'd2 || b_mem_wb_data !== 32'h0) begin
            failures++; $display("FAIL tmo_result: got v=%b exc=%0d d=%h want 1/2/0", b_mem_wb_valid, b_mem_wb_exc, b_mem_wb_data);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        @(negedge clk);
        ex_valid = 1; ex_load = 0; ex_store = 0; ex_rd_data = 32'hDEAD_BEEF; ex_rd = 5'd7;
        @(negedge clk);
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_wb_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL hold_pre: got v=%b d=%h want 1/deadbeef", mem_wb_valid, mem_wb_data);
        end
        drive_mem(1, 0, 2'd2, 0, 32'h1000, 32'd0, 32'h0, 5'd9);
        stall = 1;
        @(negedge clk);
        checks++;
        if (dddr_read !== 1'b1) begin
            failures++; $display("FAIL hold_req: got rd=%b want 1", dddr_read);
        end
        dddr_resp = 1; dddr_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dddr_resp = 0;
            if (c == 2) stall = 0;
            #1;
            checks++;
            if (mem_wb_data !== 32'hDEAD_BEEF || mem_wb_rd !== 5'd7 || mem_wb_valid !== 1'b1) begin
                failures++; $display("FAIL hold_frozen_c%0d: got v=%b d=%h rd=%0d want 1/deadbeef/7", c, mem_wb_valid, mem_wb_data, mem_wb_rd);
            end
            checks++;
            if (mem_busy !== (c < 2)) begin
                failures++; $display("FAIL hold_busy_c%0d: got %b want %b", c, mem_busy, (c < 2));
            end
        end
        @(negedge clk);
        ex_valid = 0;
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_wb_data !== 32'hCAFE_F00D || mem_wb_rd !== 5'd9 || mem_wb_exc !== 2'd0) begin
            failures++; $display("FAIL hold_release: got v=%b d=%h rd=%0d exc=%0d want 1/cafef00d/9/0",
                                 mem_wb_valid, mem_wb_data, mem_wb_rd, mem_wb_exc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        drive_mem(1, 0, 2'd2, 0, 32'h1000, 32'd4, 32'h0, 5'd2);
        @(negedge clk);
        checks++;
        if (dddr_read !== 1'b1) begin
            failures++; $display("FAIL rmid_req: got rd=%b want 1", dddr_read);
        end
        rst = 1; ex_valid = 0;
        @(negedge clk);
        rst = 0;
        checks++;
        if ({dddr_read, dddr_write, dddr_be, dddr_addr, dddr_wdata, mem_busy, mem_wb_valid} !== 72'd0) begin
            failures++; $display("FAIL rmid_clear: got rd=%b wr=%b be=%b addr=%h busy=%b v=%b want 0",
                                 dddr_read, dddr_write, dddr_be, dddr_addr, mem_busy, mem_wb_valid);
        end
        dddr_resp = 1; dddr_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dddr_resp = 0;
        checks++;
        if (mem_wb_valid !== 1'b0 || dddr_read !== 1'b0 || mem_busy !== 1'b0) begin
            failures++; $display("FAIL rmid_late_resp: got v=%b rd=%b busy=%b want 0/0/0", mem_wb_valid, dddr_read, mem_busy);
        end
    endtask

    task automatic test_random();
        int kind, dw, nb, off, dly, wcnt, cyc, widx;
        bit is_ld, is_st, mis, got_req, done;
        logic [31:0] rs1, rs2, rdd, exp_data, aoff;
        logic [63:0] v;
        logic [3:0]  exp_be;
        logic [4:0]  rd;
        logic        uns;
        do_reset();
        for (int w = 0; w < 16; w++) begin
            phys[w] = $urandom;
            for (int k = 0; k < 4; k++) model[4*w+k] = phys[w][8*k +: 8];
        end
        for (int n = 0; n < 200; n++) begin
            kind  = $urandom_range(0, 99);
            is_ld = (kind < 45);
            is_st = (kind >= 45) && (kind < 85);
            dw    = $urandom_range(0, 2);
            nb    = 1 << dw;
            off   = $urandom_range(0, 63);
            mis   = (is_ld || is_st) && (dw > 0) && ($urandom_range(0, 9) == 0);
            if (mis) off = off | 1; else off = off & ~(nb - 1);
            rs1 = $urandom; rs2 = $urandom; rdd = $urandom;
            rd  = 5'($urandom); uns = 1'($urandom); dly = $urandom_range(0, 4);

            // Reference: byte-addressed memory, plain arithmetic on the ea.
            exp_be   = 4'(((1 << nb) - 1) << (off % 4));
            exp_data = 32'h0;
            if (is_ld && !mis) begin
                v = 64'h0;
                for (int k = 0; k < nb; k++) v = v | (64'(model[off+k]) << (8*k));
                if (!uns && v[8*nb-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
                exp_data = v[31:0];
            end else if (!is_ld && !is_st) begin
                exp_data = rdd;
            end
            if (is_st && !mis) begin
                for (int k = 0; k < nb; k++) model[off+k] = rs2[8*k +: 8];
            end

            @(negedge clk);
            ex_valid = 1; ex_load = is_ld; ex_store = is_st; ex_dwidth = 2'(dw); ex_unsigned = uns;
            ex_rs1_data = rs1; ex_imm = 32'h100 + 32'(off) - rs1; ex_rs2_data = rs2;
            ex_rd_data = rdd; ex_rd = rd;

            got_req = 0; wcnt = 0; done = 0; cyc = 0;
            while (!done && cyc < 40) begin
                if (dddr_read || dddr_write) begin
                    if (!got_req) begin
                        got_req = 1;
                        checks++;
                        if (dddr_addr !== 32'h100 + 32'(off & ~3) || dddr_be !== exp_be ||
                            {dddr_read, dddr_write} !== {is_ld, is_st}) begin
                            failures++;
                            $display("FAIL rnd_req[%0d]: got addr=%h be=%b rd=%b wr=%b want %h/%b/%b/%b",
                                     n, dddr_addr, dddr_be, dddr_read, dddr_write,
                                     32'h100 + 32'(off & ~3), exp_be, is_ld, is_st);
                        end
                    end
                    if (wcnt == dly) begin
                        dddr_resp = 1;
                        aoff = dddr_addr - 32'h100;
                        if (aoff < 64) begin
                            widx = int'(aoff >> 2);
                            dddr_rdata = phys[widx];
                            if (dddr_write) begin
                                for (int k = 0; k < 4; k++)
                                    if (dddr_be[k]) phys[widx][8*k +: 8] = dddr_wdata[8*k +: 8];
                            end
                        end
                    end else begin
                        wcnt++;
                    end
                end
                #1;
                if (!mem_busy) done = 1;
                else begin
                    @(negedge clk);
                    dddr_resp = 0;
                    cyc++;
                end
            end
            if (!done) begin
                checks++; failures++;
                $display("FAIL rnd_timeout[%0d]: busy still %b after %0d cycles", n, mem_busy, cyc);
            end
            @(negedge clk);
            dddr_resp = 0; ex_valid = 0;
            checks++;
            if (got_req !== ((is_ld || is_st) && !mis)) begin
                failures++; $display("FAIL rnd_reqseen[%0d]: got %b want %b", n, got_req, ((is_ld || is_st) && !mis));
            end
            checks++;
            if (mem_wb_valid !== 1'b1 || mem_wb_rd !== rd || mem_wb_exc !== (mis ? 2'd1 : 2'd0)) begin
                failures++; $display("FAIL rnd_wb[%0d]: got v=%b rd=%0d exc=%0d want 1/%0d/%0d",
                                     n, mem_wb_valid, mem_wb_rd, mem_wb_exc, rd, (mis ? 1 : 0));
            end
            if (!is_st && !mis) begin
                checks++;
                if (mem_wb_data !== exp_data) begin
                    failures++; $display("FAIL rnd_data[%0d]: got %h want %h (ld=%b dw=%0d uns=%b off=%0d)",
                                         n, mem_wb_data, exp_data, is_ld, dw, uns, off);
                end
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_stall_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
